// File: rtl/exe_stage.sv
// Execute stage: ALU, single-cycle multiply, iterative restoring divider, data SRAM request
// generation and result forwarding to decode.
module exe_stage #(
  parameter int unsigned DS_TO_ES_BUS_WD = 151,
  parameter int unsigned ES_TO_MS_BUS_WD = 72,
  parameter int unsigned ES_TO_DS_BUS_WD = 39,
  parameter int unsigned DIV_ITERS       = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_TO_DS_BUS_WD-1:0] es_to_ds_forward_bus,
  output logic                       es_to_ds_valid,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  localparam int unsigned CntW = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {DivIdle, DivBusy, DivDone} div_state_e;

  logic                       es_valid_q;
  logic [DS_TO_ES_BUS_WD-1:0] es_bus_q;
  logic                       es_ready_go;

  logic [11:0] alu_op;
  logic [2:0]  md_op;
  logic        load_op, store_op, gr_we;
  logic [4:0]  dest;
  logic [31:0] src1, src2, rkd_value, pc;

  assign {alu_op, md_op, load_op, store_op, gr_we, dest, src1, src2, rkd_value, pc} = es_bus_q;

  assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid_q && es_ready_go;
  assign es_to_ds_valid = es_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q <= 1'b0;
    end else if (es_allowin) begin
      es_valid_q <= ds_to_es_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (ds_to_es_valid && es_allowin) begin
      es_bus_q <= ds_to_es_bus;
    end
  end

  // ALU: one-hot select folded into an AND-OR mux
  logic [31:0] alu_result;
  logic [31:0] sra_result;
  assign sra_result = $unsigned($signed(src1) >>> src2[4:0]);

  always_comb begin
    alu_result = ({32{alu_op[0]}}  & (src1 + src2))
               | ({32{alu_op[1]}}  & (src1 - src2))
               | ({32{alu_op[2]}}  & {31'b0, $signed(src1) < $signed(src2)})
               | ({32{alu_op[3]}}  & {31'b0, src1 < src2})
               | ({32{alu_op[4]}}  & (src1 & src2))
               | ({32{alu_op[5]}}  & ~(src1 | src2))
               | ({32{alu_op[6]}}  & (src1 | src2))
               | ({32{alu_op[7]}}  & (src1 ^ src2))
               | ({32{alu_op[8]}}  & (src1 << src2[4:0]))
               | ({32{alu_op[9]}}  & (src1 >> src2[4:0]))
               | ({32{alu_op[10]}} & sra_result)
               | ({32{alu_op[11]}} & src2);
  end

  // Sign-extend only for mulh; low word is identical either way
  logic        mul_signed;
  logic [63:0] mul_x, mul_y, product;
  assign mul_signed = (md_op == 3'd2);
  assign mul_x      = {{32{mul_signed & src1[31]}}, src1};
  assign mul_y      = {{32{mul_signed & src2[31]}}, src2};
  assign product    = mul_x * mul_y;

  // Divider
  logic            is_div;
  div_state_e      div_state_q, div_state_d;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     quo_q, rem_q, dvs_q;
  logic            neg_quo_q, neg_rem_q;
  logic            div_signed, s1_neg, s2_neg;
  logic [32:0]     rem_shift;
  logic            rem_ge;
  logic [31:0]     rem_diff;
  logic [31:0]     div_result;

  assign is_div     = md_op[2];
  assign div_signed = !md_op[0];
  assign s1_neg     = div_signed & src1[31];
  assign s2_neg     = div_signed & src2[31];

  assign rem_shift = {rem_q, quo_q[31]};
  assign rem_ge    = rem_shift[32] || (rem_shift[31:0] >= dvs_q);
  assign rem_diff  = rem_shift[31:0] - dvs_q;

  assign div_result = md_op[1] ? (neg_rem_q ? -rem_q : rem_q) : (neg_quo_q ? -quo_q : quo_q);
  assign es_ready_go = !is_div || (div_state_q == DivDone);

  always_comb begin
    div_state_d = div_state_q;
    unique case (div_state_q)
      DivIdle: if (es_valid_q && is_div) div_state_d = DivBusy;
      DivBusy: if (cnt_q == '0) div_state_d = DivDone;
      DivDone: if (es_to_ms_valid && ms_allowin) div_state_d = DivIdle;
      default: div_state_d = DivIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_state_q <= DivIdle;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else begin
      div_state_q <= div_state_d;
      if (div_state_q == DivIdle && es_valid_q && is_div) begin
        quo_q     <= s1_neg ? -src1 : src1;
        dvs_q     <= s2_neg ? -src2 : src2;
        rem_q     <= '0;
        neg_quo_q <= s1_neg ^ s2_neg;
        neg_rem_q <= s1_neg;
        cnt_q     <= CntW'(DIV_ITERS - 1);
      end else if (div_state_q == DivBusy) begin
        rem_q <= rem_ge ? rem_diff : rem_shift[31:0];
        quo_q <= {quo_q[30:0], rem_ge};
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  logic [31:0] mem_addr;
  logic [31:0] exe_result;
  assign mem_addr = src1 + src2;

  always_comb begin
    exe_result = alu_result;
    case (md_op)
      3'd1:                    exe_result = product[31:0];
      3'd2, 3'd3:              exe_result = product[63:32];
      3'd4, 3'd5, 3'd6, 3'd7:  exe_result = div_result;
      default:                 exe_result = alu_result;
    endcase
    if (load_op) exe_result = mem_addr;
  end

  logic forward_enable, dep_need_stall;
  assign forward_enable = es_valid_q && gr_we && (dest != 5'd0);
  assign dep_need_stall = es_valid_q && (load_op || (is_div && div_state_q != DivDone));

  assign es_to_ms_bus         = {store_op, load_op, gr_we, dest, exe_result, pc};
  assign es_to_ds_forward_bus = {dep_need_stall, forward_enable, dest, exe_result};

  assign data_sram_en    = !reset && es_valid_q && (load_op || store_op) && ms_allowin;
  assign data_sram_we    = {4{!reset && store_op && es_valid_q}} & 4'hF;
  assign data_sram_addr  = reset ? 32'd0 : mem_addr;
  assign data_sram_wdata = reset ? 32'd0 : rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed corner cases then randomized traffic.
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [150:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [71:0]  es_to_ms_bus;
  logic [38:0]  es_to_ds_forward_bus;
  logic         es_to_ds_valid;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  exe_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .ms_allowin          (ms_allowin),
    .es_allowin          (es_allowin),
    .ds_to_es_valid      (ds_to_es_valid),
    .ds_to_es_bus        (ds_to_es_bus),
    .es_to_ms_valid      (es_to_ms_valid),
    .es_to_ms_bus        (es_to_ms_bus),
    .es_to_ds_forward_bus(es_to_ds_forward_bus),
    .es_to_ds_valid      (es_to_ds_valid),
    .data_sram_en        (data_sram_en),
    .data_sram_we        (data_sram_we),
    .data_sram_addr      (data_sram_addr),
    .data_sram_wdata     (data_sram_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] ms_bus;
    logic [38:0] fwd;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  bit   rand_mode = 1'b0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int idx, input logic [31:0] a, input logic [31:0] b);
    case (idx)
      0:       return a + b;
      1:       return a - b;
      2:       return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:       return (a < b) ? 32'd1 : 32'd0;
      4:       return a & b;
      5:       return ~(a | b);
      6:       return a | b;
      7:       return a ^ b;
      8:       return a << b[4:0];
      9:       return a >> b[4:0];
      10:      return $unsigned($signed(a) >>> b[4:0]);
      default: return b;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] md, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb2;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic            sgn, n1, n2;
    logic [31:0]     ma, mb, q, r;
    sa = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (md == 3'd1) begin
      p = ua * ub;
      return p[31:0];
    end else if (md == 3'd2) begin
      p = sa * sb2;
      return p[63:32];
    end else if (md == 3'd3) begin
      p = ua * ub;
      return p[63:32];
    end
    sgn = !md[0];
    n1 = sgn && a[31];
    n2 = sgn && b[31];
    ma = n1 ? -a : a;
    mb = n2 ? -b : b;
    q = (mb == 0) ? 32'hFFFF_FFFF : ma / mb;
    r = (mb == 0) ? ma : ma % mb;
    if (n1 != n2) q = -q;
    if (n1) r = -r;
    return md[1] ? r : q;
  endfunction

  task automatic issue(input logic [150:0] bus, input exp_t e);
    bit accepted = 1'b0;
    ds_to_es_bus = bus;
    ds_to_es_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (es_allowin) begin
        sb.push_back(e);
        accepted = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (rand_mode) ms_allowin = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    ds_to_es_valid = 1'b0;
    if (rand_mode) ms_allowin = ($urandom_range(0, 3) != 0);
    if (!accepted) begin
      vectors++;
      miscompares++;
      $display("FAIL issue_timeout: got es_allowin=0 for 300 cycles expected acceptance");
    end
  endtask

  task automatic send(input int idx, input logic [2:0] md, input logic ld, input logic st,
                      input logic gwe, input logic [4:0] dest, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] rkd, input logic [31:0] pc);
    logic [11:0]  oh;
    logic [31:0]  res;
    logic [150:0] bus;
    exp_t         e;
    oh = 12'd1 << idx;
    bus = {oh, md, ld, st, gwe, dest, a, b, rkd, pc};
    res = ld ? a + b : (md == 3'd0 ? ref_alu(idx, a, b) : ref_md(md, a, b));
    e.ms_bus = {st, ld, gwe, dest, res, pc};
    e.fwd = {ld, gwe && (dest != 5'd0), dest, res};
    e.en = ld || st;
    e.we = st ? 4'hF : 4'h0;
    e.addr = a + b;
    e.wdata = rkd;
    issue(bus, e);
  endtask

  task automatic drain();
    ms_allowin = 1'b1;
    for (int c = 0; c < 200 && es_to_ds_valid !== 1'b0; c++) @(negedge clk);
    check("drain_empty", 72'(es_to_ds_valid), 72'(0));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pop and compare every transfer into mem_stage
  always @(negedge clk) begin
    if (!reset) begin
      if (es_to_ms_valid && ms_allowin) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got bus %h expected no transfer", es_to_ms_bus);
        end else begin
          mon_e = sb.pop_front();
          check("ms_bus", 72'(es_to_ms_bus), mon_e.ms_bus);
          check("fwd_bus", 72'(es_to_ds_forward_bus), 72'(mon_e.fwd));
          check("sram_en_we", 72'({data_sram_en, data_sram_we}), 72'({mon_e.en, mon_e.we}));
          if (mon_e.en)
            check("sram_addr_wdata", 72'({data_sram_addr, data_sram_wdata}),
                  72'({mon_e.addr, mon_e.wdata}));
        end
      end else begin
        check("sram_en_idle", 72'(data_sram_en), 72'(0));
      end
    end
  end

  initial begin
    int n;
    logic [31:0] exp_res;
    reset = 1'b1;
    ms_allowin = 1'b0;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_sram", 72'({data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata}), 72'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", 72'({es_to_ms_valid, es_allowin, es_to_ds_valid}), 72'(3'b010));
    @(posedge clk);
    #1;

    // ADD, one cycle through
    ms_allowin = 1'b1;
    send(0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd5, 32'd7, 32'd0, 32'h1C00_0000);
    @(negedge clk);
    check("add_latency", 72'(es_to_ms_valid), 72'(1));
    drain();

    // DIV latency: ready_go low for 33 cycles after the latching edge
    send(0, 3'd4, 1'b0, 1'b0, 1'b1, 5'd4, 32'd100, 32'd7, 32'd0, 32'h1C00_0004);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (es_to_ms_valid) break;
      n++;
    end
    check("div_latency", 72'(n), 72'(33));
    drain();

    send(0, 3'd6, 1'b0, 1'b0, 1'b1, 5'd5, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'h1C00_0008);
    send(0, 3'd5, 1'b0, 1'b0, 1'b1, 5'd6, 32'd5, 32'd0, 32'd0, 32'h1C00_000C);
    send(0, 3'd7, 1'b0, 1'b0, 1'b1, 5'd7, 32'd5, 32'd0, 32'd0, 32'h1C00_0010);
    send(0, 3'd4, 1'b0, 1'b0, 1'b1, 5'd8, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h1C00_0014);
    send(0, 3'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h100, 32'd4, 32'hDEAD_BEEF, 32'h1C00_0018);
    send(0, 3'd0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h200, 32'd8, 32'd0, 32'h1C00_001C);
    drain();

    // Back-pressure while the divider holds its result
    ms_allowin = 1'b0;
    exp_res = ref_md(3'd4, 32'hFFFF_FF9C, 32'd7);
    send(0, 3'd4, 1'b0, 1'b0, 1'b1, 5'd10, 32'hFFFF_FF9C, 32'd7, 32'd0, 32'h1C00_0020);
    for (int c = 0; c < 100 && !es_to_ms_valid; c++) @(negedge clk);
    repeat (5) begin
      check("hold_valid_allowin", 72'({es_to_ms_valid, es_allowin}), 72'(2'b10));
      check("hold_result", 72'(es_to_ms_bus[63:32]), 72'(exp_res));
      check("hold_no_stall", 72'(es_to_ds_forward_bus[38]), 72'(0));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    ms_allowin = 1'b1;
    drain();

    // Reset in the middle of a divide drops the instruction
    send(0, 3'd4, 1'b0, 1'b0, 1'b1, 5'd11, 32'd1000, 32'd3, 32'd0, 32'h1C00_0024);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_sram", 72'({data_sram_en, data_sram_we}), 72'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("reset_mid_state", 72'({es_to_ds_valid, es_allowin, es_to_ds_forward_bus[38]}),
          72'(3'b010));
    @(posedge clk);
    #1;
    send(0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd12, 32'd20, 32'd22, 32'd0, 32'h1C00_0028);
    @(negedge clk);
    check("add_after_reset", 72'(es_to_ms_valid), 72'(1));
    drain();

    // Randomized traffic with random back-pressure
    rand_mode = 1'b1;
    for (int t = 0; t < 300; t++) begin
      int          idx, r;
      logic [2:0]  md;
      logic        ld, st;
      r = $urandom_range(0, 9);
      md = (r < 6) ? 3'd0 : (r < 8) ? 3'($urandom_range(1, 3)) : 3'($urandom_range(4, 7));
      idx = $urandom_range(0, 11);
      r = $urandom_range(0, 7);
      ld = (r == 0);
      st = (r == 1);
      if (ld || st) begin
        md = 3'd0;
        idx = 0;
      end
      send(idx, md, ld, st, 1'($urandom), 5'($urandom), rnd_op(), rnd_op(), $urandom, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
        ms_allowin = ($urandom_range(0, 3) != 0);
      end
    end
    rand_mode = 1'b0;
    ms_allowin = 1'b1;
    for (int c = 0; c < 500 && sb.size() != 0; c++) @(negedge clk);
    check("final_scoreboard_empty", 72'(sb.size()), 72'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
